// File: rtl/eq4_pkg.sv
// Shared types for the 4-state equality pipeline: opcodes, the {aval,bval}
// encoding of one 4-state bit, and small helpers used by the compare stage.
package eq4_pkg;

    typedef enum logic [1:0] {
        OP_EQ  = 2'd0,
        OP_NE  = 2'd1,
        OP_CEQ = 2'd2,
        OP_CNE = 2'd3
    } op_e;

    // One 4-state bit packed as {aval, bval}.
    localparam logic [1:0] V4_0 = 2'b00;
    localparam logic [1:0] V4_1 = 2'b10;
    localparam logic [1:0] V4_X = 2'b11;
    localparam logic [1:0] V4_Z = 2'b01;

    function automatic int max_w(int wa, int wb);
        return (wa > wb) ? wa : wb;
    endfunction

    // Logical NOT of a 4-state bit; unknowns (x or z) come out as x.
    function automatic logic [1:0] v4_not(logic [1:0] v);
        case (v)
            V4_0:       return V4_1;
            V4_1:       return V4_0;
            V4_X, V4_Z: return V4_X;
            default:    return V4_X;
        endcase
    endfunction

    function automatic logic [1:0] v4_from_bool(logic b);
        return b ? V4_1 : V4_0;
    endfunction

endpackage

// File: rtl/eq4_compare_pipe_if.sv
// Operand/result bundle for the equality pipeline. The master drives operands
// and consumes results; the slave is the pipeline itself.
interface eq4_compare_pipe_if #(
    parameter int WA = 8,
    parameter int WB = 8,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [WA-1:0] a_aval;
    logic [WA-1:0] a_bval;
    logic          a_signed;
    logic [WB-1:0] b_aval;
    logic [WB-1:0] b_bval;
    logic          b_signed;
    logic          out_valid;
    logic          out_ready;
    logic          res_aval;
    logic          res_bval;
    logic [CW-1:0] x_count;

    modport master (
        output in_valid, op, a_aval, a_bval, a_signed, b_aval, b_bval, b_signed, out_ready,
        input  in_ready, out_valid, res_aval, res_bval, x_count
    );

    modport slave (
        input  in_valid, op, a_aval, a_bval, a_signed, b_aval, b_bval, b_signed, out_ready,
        output in_ready, out_valid, res_aval, res_bval, x_count
    );

    modport monitor (
        input in_valid, in_ready, op, a_aval, a_bval, a_signed, b_aval, b_bval, b_signed,
              out_valid, out_ready, res_aval, res_bval, x_count
    );
endinterface

// File: rtl/eq4_extend.sv
// Widens one 4-state operand from WI to WO bits. With sext_i the MSB of both
// planes is replicated (so an x/z sign bit stays x/z); otherwise pad is 0.
module eq4_extend #(
    parameter int WI = 8,
    parameter int WO = 8
) (
    input  logic          sext_i,
    input  logic [WI-1:0] aval_i,
    input  logic [WI-1:0] bval_i,
    output logic [WO-1:0] aval_o,
    output logic [WO-1:0] bval_o
);

    genvar gi;
    generate
        for (gi = 0; gi < WO; gi++) begin : g_bit
            if (gi < WI) begin : g_pass
                assign aval_o[gi] = aval_i[gi];
                assign bval_o[gi] = bval_i[gi];
            end else begin : g_pad
                assign aval_o[gi] = sext_i & aval_i[WI-1];
                assign bval_o[gi] = sext_i & bval_i[WI-1];
            end
        end

        // The widest operand never needs padding, so its sign mode is irrelevant.
        if (WO <= WI) begin : g_noext
            logic unused_sext;
            assign unused_sext = sext_i;
        end
    endgenerate

endmodule

// File: rtl/eq4_compare_pipe.sv
// Two-stage 4-state ==, !=, ===, !== unit with valid/ready on both sides.
// Stage 1 registers width-extended operands; stage 2 registers the result.
module eq4_compare_pipe
    import eq4_pkg::*;
#(
    parameter int WA = 8,
    parameter int WB = 8,
    parameter int CW = 16
) (
    input logic               clk,
    input logic               reset,
    eq4_compare_pipe_if.slave bus
);

    localparam int W = max_w(WA, WB);

    // ---------------- handshake ----------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s2_load;
    logic s1_load;
    logic in_fire;
    logic out_fire;

    assign s2_load  = ~s2_valid_q | bus.out_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    // Gated by reset so nothing is accepted into a pipeline that is being cleared.
    assign bus.in_ready = ~reset & s1_load;
    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = s2_valid_q & bus.out_ready;

    // ---------------- stage 1: extend ----------------
    logic         ext_signed;
    logic [W-1:0] a_aval_ext;
    logic [W-1:0] a_bval_ext;
    logic [W-1:0] b_aval_ext;
    logic [W-1:0] b_bval_ext;

    assign ext_signed = bus.a_signed & bus.b_signed;

    eq4_extend #(.WI(WA), .WO(W)) u_ext_a (
        .sext_i (ext_signed),
        .aval_i (bus.a_aval),
        .bval_i (bus.a_bval),
        .aval_o (a_aval_ext),
        .bval_o (a_bval_ext)
    );

    eq4_extend #(.WI(WB), .WO(W)) u_ext_b (
        .sext_i (ext_signed),
        .aval_i (bus.b_aval),
        .bval_i (bus.b_bval),
        .aval_o (b_aval_ext),
        .bval_o (b_bval_ext)
    );

    op_e          s1_op_q;
    logic [W-1:0] s1_a_aval_q;
    logic [W-1:0] s1_a_bval_q;
    logic [W-1:0] s1_b_aval_q;
    logic [W-1:0] s1_b_bval_q;

    // ---------------- stage 2: compare ----------------
    logic [W-1:0] known_diff;
    logic [W-1:0] unk;
    logic         ident;
    logic [1:0]   eq_v;
    logic [1:0]   res_v;
    logic         res_aval_q, res_aval_d;
    logic         res_bval_q, res_bval_d;
    logic [CW-1:0] x_count_q, x_count_d;

    assign known_diff = ~s1_a_bval_q & ~s1_b_bval_q & (s1_a_aval_q ^ s1_b_aval_q);
    assign unk        = s1_a_bval_q | s1_b_bval_q;
    assign ident      = (s1_a_aval_q == s1_b_aval_q) && (s1_a_bval_q == s1_b_bval_q);

    // A known mismatch anywhere decides == even when other bits are unknown.
    always_comb begin
        eq_v  = (|known_diff) ? V4_0 : ((|unk) ? V4_X : V4_1);
        res_v = eq_v;
        case (s1_op_q)
            OP_EQ:   res_v = eq_v;
            OP_NE:   res_v = v4_not(eq_v);
            OP_CEQ:  res_v = v4_from_bool(ident);
            OP_CNE:  res_v = v4_from_bool(~ident);
            default: res_v = eq_v;
        endcase
        res_aval_d = res_v[1];
        res_bval_d = res_v[0];
    end

    always_comb begin
        x_count_d = x_count_q;
        if (out_fire && res_bval_q && (x_count_q != {CW{1'b1}})) begin
            x_count_d = x_count_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_EQ;
            s1_a_aval_q <= '0;
            s1_a_bval_q <= '0;
            s1_b_aval_q <= '0;
            s1_b_bval_q <= '0;
            s2_valid_q  <= 1'b0;
            res_aval_q  <= 1'b0;
            res_bval_q  <= 1'b0;
            x_count_q   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_fire;
                if (in_fire) begin
                    s1_op_q     <= op_e'(bus.op);
                    s1_a_aval_q <= a_aval_ext;
                    s1_a_bval_q <= a_bval_ext;
                    s1_b_aval_q <= b_aval_ext;
                    s1_b_bval_q <= b_bval_ext;
                end
            end
            // Result registers only move when stage 2 may advance, so a stalled
            // output keeps presenting the same value.
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_aval_q <= res_aval_d;
                    res_bval_q <= res_bval_d;
                end
            end
            x_count_q <= x_count_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.res_aval  = res_aval_q;
    assign bus.res_bval  = res_bval_q;
    assign bus.x_count   = x_count_q;

endmodule
